// File: rtl/div_defs_pkg.sv
// Shared divider definitions: FSM state encodings and the default operand width.
// No logic; imported by the divider and its testbench.
package div_defs;
    localparam int DIV_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block for ripple-carry arithmetic.
// Purely combinational; no flow control.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/rc_subtractor.sv
// Ripple-carry subtractor a - b built as a + ~b + 1 on full_adder cells.
// Combinational; borrow is the inverted carry-out of the top cell.
module rc_subtractor #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);
    logic [W:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (~b_i[i]),
            .c_i (carry[i]),
            .s_o (diff_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign borrow_o = ~carry[W];
endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider (signed DIV / unsigned DIVU), one quotient bit per cycle.
// Latency N+1 cycles from accepted start to done; start is ignored while busy.
module seq_divider
    import div_defs::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dbz
);
    localparam int         CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_e    state_q, state_d;
    logic [N:0]    rem_q, rem_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  bmag_q, bmag_d;
    logic [N-1:0]  araw_q, araw_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          bzero_q, bzero_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rmd_q, rmd_d;
    logic          dbz_q, dbz_d;

    logic          accept;
    logic          a_neg, b_neg;
    logic [N-1:0]  a_mag, b_mag;
    logic [N:0]    trial, diff;
    logic          borrow;
    logic [N-1:0]  qmag, rmag;

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign a_neg  = is_signed & a[N-1];
    assign b_neg  = is_signed & b[N-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    // Partial remainder stays below the divisor magnitude, so the shift never loses its top bit.
    assign trial = {rem_q[N-1:0], dvd_q[N-1]};

    rc_subtractor #(.W(N + 1)) u_sub (
        .a_i      (trial),
        .b_i      ({1'b0, bmag_q}),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    assign qmag = {dvd_q[N-2:0], ~borrow};
    assign rmag = borrow ? trial[N-1:0] : diff[N-1:0];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        bmag_d  = bmag_q;
        araw_d  = araw_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        bzero_d = bzero_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        case (state_q)
            RUN: begin
                rem_d = borrow ? trial : diff;
                dvd_d = qmag;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    dbz_d   = bzero_q;
                    if (bzero_q) begin
                        quo_d = '1;
                        rmd_d = araw_q;
                    end else begin
                        quo_d = qneg_q ? -qmag : qmag;
                        rmd_d = rneg_q ? -rmag : rmag;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = RUN;
            rem_d   = '0;
            dvd_d   = a_mag;
            bmag_d  = b_mag;
            araw_d  = a;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            bzero_d = (b == '0);
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            bmag_q  <= '0;
            araw_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            bmag_q  <= bmag_d;
            araw_q  <= araw_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            bzero_q <= bzero_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign q    = quo_q;
    assign r    = rmd_q;
    assign dbz  = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed operations push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_divider;
    localparam int N = 32;

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, dbz;
    logic [31:0] q, r;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Caller is positioned at a negedge; start is raised for exactly one cycle.
    task automatic issue(input string nm, input logic sgn, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eq,
                         input logic [31:0] er, input logic edbz, input bit expect_done);
        exp_t e;
        is_signed = sgn;
        a = av;
        b = bv;
        start = 1'b1;
        if (expect_done) begin
            e.name = nm; e.q = eq; e.r = er; e.dbz = edbz; e.cyc = cyc + N + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_q"}, 64'(q), 64'(e.q));
                chk({e.name, "_r"}, 64'(r), 64'(e.r));
                chk({e.name, "_dbz"}, 64'(dbz), 64'(e.dbz));
                chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                chk({e.name, "_busy"}, 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        int c0;
        int ndone;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q", 64'(q), 64'd0);
        chk("rst_r", 64'(r), 64'd0);
        chk("rst_dbz", 64'(dbz), 64'd0);
        reset = 1'b0;

        @(negedge clk); issue("u100_7", 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 1);
        drain();
        @(negedge clk); issue("s_m7_2", 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 1);
        drain();
        @(negedge clk); issue("s_7_m2", 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 1);
        drain();
        @(negedge clk); issue("s_min_m1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 1);
        drain();
        @(negedge clk); issue("u_min_m1", 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 1);
        drain();
        @(negedge clk); issue("u5_0", 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 1);
        drain();
        @(negedge clk); issue("s5_0", 1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 1);
        drain();
        @(negedge clk); issue("s_m5_0", 1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 1);
        drain();
        @(negedge clk); issue("u10_3", 0, 32'd10, 32'd3, 32'd3, 32'd1, 0, 1);
        drain();
        @(negedge clk); issue("u_max_1", 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 1);
        drain();

        // A start pulse with new operands while iterating must not disturb the result.
        @(negedge clk); issue("u200_9", 0, 32'd200, 32'd9, 32'd22, 32'd2, 0, 1);
        repeat (4) @(negedge clk);
        chk("midrun_busy", 64'(busy), 64'd1);
        issue("ignored", 1, 32'd1, 32'd1, 32'd0, 32'd0, 0, 0);
        drain();

        // Second start lands in the DONE cycle of the first operation.
        @(negedge clk); issue("u50_5", 0, 32'd50, 32'd5, 32'd10, 32'd0, 0, 1);
        repeat (N) @(negedge clk);
        chk("b2b_done_now", 64'(done), 64'd1);
        issue("s_m1000_7", 1, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, 32'hFFFF_FFFA, 0, 1);
        drain();

        // Reset in RUN cycle 10 aborts the operation with no done pulse.
        @(negedge clk);
        c0 = cyc;
        issue("aborted", 0, 32'd1000, 32'd3, 32'd0, 32'd0, 0, 0);
        repeat (9) @(negedge clk);
        chk("abort_run_cycle", 64'(cyc - c0), 64'd10);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_q", 64'(q), 64'd0);
        chk("abort_r", 64'(r), 64'd0);
        chk("abort_dbz", 64'(dbz), 64'd0);
        reset = 1'b0;
        ndone = 0;
        repeat (N + 5) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request a divide; sampled only in IDLE or DONE.
REQ-005 SHALL have port is_signed, input, 1, 1 = two's-complement DIV, 0 = unsigned DIVU; sampled with start.
REQ-006 SHALL have port a, input, N, dividend; sampled with start.
REQ-007 SHALL have port b, input, N, divisor; sampled with start.
REQ-008 SHALL have port busy, output, 1, high while iterating.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when results are valid.
REQ-010 SHALL have port q, output, N, quotient (LO).
REQ-011 SHALL have port r, output, N, remainder (HI).
REQ-012 SHALL have port dbz, output, 1, divide-by-zero flag for the last completed operation.

Function
REQ-013 SHALL implement a restoring shift-subtract divider with states IDLE, RUN and DONE.
REQ-014 SHALL accept start in IDLE or DONE: latch operand magnitudes, signs, is_signed and b==0; clear the step counter; go to RUN.
REQ-015 SHALL ignore start while in RUN; operands and mode SHALL be unaffected.
REQ-016 SHALL execute exactly N RUN cycles, each shifting one dividend bit into the partial remainder and performing one (N+1)-bit trial subtraction of the divisor magnitude.
REQ-017 SHALL, on each trial subtraction, keep the difference and shift in a quotient bit of 1 when there is no borrow; otherwise it SHALL keep the remainder and shift in a 0.
REQ-018 SHALL, for start accepted in cycle T, hold busy=1 in cycles T+1..T+N and done=1 only in cycle T+N+1, with busy=0.
REQ-019 SHALL leave DONE for IDLE after one cycle unless start is accepted in DONE.
REQ-020 SHALL register q, r and dbz at the end of the last RUN cycle and hold them stable until the next completion or reset.
REQ-021 SHALL, when is_signed=1, divide magnitudes and then negate q when sign(a) XOR sign(b), and negate r when sign(a)=1 (C-style truncation).
REQ-022 SHALL return q=0x80000000 and r=0 for signed 0x80000000 / 0xFFFFFFFF (N=32), with no trap and no flag.
REQ-023 SHALL, for b==0 in either mode, take the full latency and produce q=all-ones, r=a (raw), dbz=1; otherwise dbz=0.
REQ-024 SHALL compute all arithmetic modulo 2^N; the internal partial remainder SHALL be N+1 bits.

Reset
REQ-025 SHALL, when reset=1 at a clock edge, enter IDLE and clear busy, done, q, r, dbz and the step counter to 0, in any state including mid-RUN.
REQ-026 SHALL give reset priority over a simultaneous start.

Structure
REQ-027 SHALL put the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default N in a shared div_defs package/header.
REQ-028 SHALL instantiate one sub-module, rc_subtractor, for the (N+1)-bit trial subtraction; it SHALL be built on the team full_adder cells using a + ~b with carry-in 1, and its borrow SHALL be the inverted carry-out.

Verification
REQ-029 SHALL cover: unsigned 100/7 -> q=14, r=2, dbz=0, with done exactly N+1 cycles after the start edge.
REQ-030 SHALL cover: signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=1.
REQ-031 SHALL cover: signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; the same operands unsigned -> q=0, r=0x80000000.
REQ-032 SHALL cover: 5/0 (both modes) -> q=0xFFFFFFFF, r=5, dbz=1; then 10/3 -> q=3, r=1, dbz=0.
REQ-033 SHALL cover: start pulsed mid-RUN with new operands -> ignored, and the original result is delivered on schedule; then back-to-back start in the DONE cycle -> second result at T+N+1 relative to that cycle.
REQ-034 SHALL cover: reset asserted in RUN cycle 10 -> next cycle busy=0, done=0, q=r=0, dbz=0; no done pulse follows.
